// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types and constants for the NTT stage controller.
// Holds the FSM state enum, core geometry and the stage twiddle helper.
package ntt_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } ntt_state_e;

  localparam int NUM_CORES   = 8;
  localparam int BF_PER_CORE = 16;
  localparam int LEN_FIRST   = 128;
  localparam int LEN_LAST    = 2;
  localparam int NUM_STAGES  = 7;

  // First twiddle index of a stage; inverse order walks it downward.
  function automatic logic [6:0] zeta_of(
    input logic [2:0] stage,
    input logic       inv
  );
    zeta_of = inv ? (7'd64 >> stage) : (7'd1 << stage);
  endfunction

endpackage

// File: rtl/ntt_stage_ctrl_if.sv
// ntt_stage_ctrl_if: control/issue bundle between sequencer and NTT cores.
// Optional inverse request exists only with NTT_CTRL_INTT_EN defined.
interface ntt_stage_ctrl_if #(
  parameter int LEN_WIDTH = 8
);

  logic                 start;
  logic                 stall;
`ifdef NTT_CTRL_INTT_EN
  logic                 inverse;
`endif
  logic                 busy;
  logic                 done;
  logic [LEN_WIDTH-1:0] len;
  logic                 rd_valid;
  logic [3:0]           rd_idx;
  logic [6:0]           zeta_base;
  logic                 wr_valid;
  logic [3:0]           wr_idx;
  logic [LEN_WIDTH-1:0] wr_len;

  modport master (
`ifdef NTT_CTRL_INTT_EN
    output inverse,
`endif
    output start,
    output stall,
    input  busy,
    input  done,
    input  len,
    input  rd_valid,
    input  rd_idx,
    input  zeta_base,
    input  wr_valid,
    input  wr_idx,
    input  wr_len
  );

  modport slave (
`ifdef NTT_CTRL_INTT_EN
    input  inverse,
`endif
    input  start,
    input  stall,
    output busy,
    output done,
    output len,
    output rd_valid,
    output rd_idx,
    output zeta_base,
    output wr_valid,
    output wr_idx,
    output wr_len
  );

endinterface

// File: rtl/ntt_delay_line.sv
// ntt_delay_line: stall-aware shift register of DEPTH stages.
// Output equals the input DEPTH unstalled cycles earlier.
module ntt_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Shift one stage per unstalled cycle; clear everything on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (!stall_i) begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: sequences the 7 NTT butterfly stages across 8 cores.
// Optional feature macro: NTT_CTRL_INTT_EN adds the inverse stage order.
module ntt_stage_ctrl
  import ntt_pkg::*;
#(
  parameter int BF_LATENCY = 4,
  parameter int LEN_WIDTH  = 8
) (
  input logic              clk,
  input logic              rst_n,
  ntt_stage_ctrl_if.slave  bus
);

  localparam int DW = 5 + LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_F = LEN_WIDTH'(LEN_FIRST);
  localparam logic [LEN_WIDTH-1:0] LEN_L = LEN_WIDTH'(LEN_LAST);
  localparam logic [3:0] IDX_END  = 4'(BF_PER_CORE - 1);
  localparam logic [3:0] DRN_END  = 4'(BF_LATENCY - 1);

  ntt_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [3:0]           idx_q, idx_d;
  logic [2:0]           stage_q, stage_d;
  logic [3:0]           dcnt_q, dcnt_d;

  logic inv_s;
  logic inv_start;
  logic accept;
  logic drain_end;
  logic last_stage;

  logic                 busy_w;
  logic                 done_w;
  logic                 rd_valid_w;
  logic [3:0]           rd_idx_w;
  logic [6:0]           zeta_w;
  logic [DW-1:0]        dl_in;
  logic [DW-1:0]        dl_out;

  assign accept     = !bus.stall && bus.start && (state_q == S_IDLE);
  assign drain_end  = (dcnt_q == DRN_END);
  assign last_stage = inv_s ? (len_q == LEN_F) : (len_q == LEN_L);

`ifdef NTT_CTRL_INTT_EN
  logic inv_q;

  // Latch the transform direction together with an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (accept) begin
      inv_q <= bus.inverse;
    end
  end

  assign inv_s     = inv_q;
  assign inv_start = bus.inverse;
`else
  assign inv_s     = 1'b0;
  assign inv_start = 1'b0;
`endif

  // State and counter registers; stall freezes all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      dcnt_q  <= '0;
    end else if (!bus.stall) begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next state and counter values for one unstalled cycle.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          len_d   = inv_start ? LEN_L : LEN_F;
          idx_d   = '0;
          stage_d = '0;
          dcnt_d  = '0;
        end
      end
      S_RUN: begin
        idx_d  = idx_q + 4'd1;
        dcnt_d = '0;
        if (idx_q == IDX_END) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 4'd1;
        if (drain_end) begin
          dcnt_d = '0;
          if (last_stage) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            len_d   = inv_s ? (len_q << 1) : (len_q >> 1);
            stage_d = stage_q + 3'd1;
            idx_d   = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        len_d   = '0;
        stage_d = '0;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        len_d   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy_w     = 1'b0;
    done_w     = 1'b0;
    rd_valid_w = 1'b0;
    rd_idx_w   = '0;
    zeta_w     = '0;
    unique case (1'b1)
      (state_q == S_RUN): begin
        busy_w     = 1'b1;
        rd_valid_w = 1'b1;
        rd_idx_w   = idx_q;
        zeta_w     = zeta_of(stage_q, inv_s);
      end
      (state_q == S_DRAIN): begin
        busy_w = 1'b1;
        zeta_w = zeta_of(stage_q, inv_s);
      end
      (state_q == S_DONE): begin
        busy_w = 1'b1;
        done_w = 1'b1;
      end
      default: begin
        busy_w = 1'b0;
      end
    endcase
  end

  assign dl_in = {rd_valid_w, rd_idx_w, len_q};

  ntt_delay_line #(
    .DEPTH (BF_LATENCY),
    .WIDTH (DW)
  ) u_wr_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall_i (bus.stall),
    .d_i     (dl_in),
    .q_o     (dl_out)
  );

  assign bus.busy      = busy_w;
  assign bus.done      = done_w;
  assign bus.len       = len_q;
  assign bus.rd_valid  = rd_valid_w;
  assign bus.rd_idx    = rd_idx_w;
  assign bus.zeta_base = zeta_w;
  assign bus.wr_valid  = dl_out[DW-1];
  assign bus.wr_idx    = dl_out[DW-2 -: 4];
  assign bus.wr_len    = dl_out[LEN_WIDTH-1:0];

endmodule

// File: doc/ntt_stage_ctrl.md
NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

Interface
REQ-001 SHALL have parameter BF_LATENCY, default 4, meaning butterfly read-to-write pipeline depth in cycles (legal range 1..15).
REQ-002 SHALL have parameter LEN_WIDTH, default 8, meaning width of the len output.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  request a full 7-stage transform; honoured only in IDLE.
REQ-006 SHALL have port stall  in  1  freezes all state, counters and the delay line while high.
REQ-007 SHALL have port busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port len  out  LEN_WIDTH  current stage length, driven to the per-core address decoder.
REQ-010 SHALL have port rd_valid  out  1  read/butterfly issue strobe for all 8 cores.
REQ-011 SHALL have port rd_idx  out  4  butterfly index (0..15) within each core's 32-word region.
REQ-012 SHALL have port zeta_base  out  7  first twiddle index of the current stage.
REQ-013 SHALL have ports wr_valid, wr_idx[3:0], wr_len[LEN_WIDTH-1:0]  out  write-back strobe, index and len, equal to rd_valid, rd_idx and len delayed by BF_LATENCY cycles.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE -> RUN SHALL occur on an edge with start=1 and stall=0; len SHALL load 128, rd_idx 0, stage counter 0.
REQ-016 In RUN, rd_valid SHALL be 1 and rd_idx SHALL increment by 1 on each unstalled cycle; after rd_idx=15, state SHALL go to DRAIN.
REQ-017 DRAIN SHALL last exactly BF_LATENCY unstalled cycles with rd_valid=0 and len held (RAW hazard between stages).
REQ-018 At the end of DRAIN: if len=2, go to DONE; otherwise halve len, increment the stage counter, clear rd_idx, and go to RUN.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE; len SHALL return to 0.
REQ-020 zeta_base SHALL equal 1 << stage (1, 2, 4, ... 64) in RUN and DRAIN, and 0 in IDLE.
REQ-021 Total latency, unstalled: done SHALL be high in the cycle following edge 7*(16+BF_LATENCY) after the start edge; 112 rd_valid and 112 wr_valid beats per run.
REQ-022 start in any state other than IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-023 While stall=1, no state, counter or delay-line stage SHALL change; outputs SHALL hold.
REQ-024 All wr_valid beats of a stage SHALL complete before the first rd_valid of the next stage.

Reset
REQ-025 With rst_n=0 the block SHALL immediately enter IDLE and clear every output and delay-line stage to 0, including mid-run.
REQ-026 The first start after reset release SHALL begin a clean run from len=128.

Configuration
REQ-027 With NTT_CTRL_INTT_EN defined, the block SHALL add input inverse (1 bit, sampled with start) and SHALL run the inverse order when it is set: len 2, 4, ... 128, and zeta_base 64, 32, ... 1.
REQ-028 Without NTT_CTRL_INTT_EN, the inverse port SHALL be absent and only the forward order SHALL exist.

Structure
REQ-029 Package ntt_pkg SHALL hold the state enum, NUM_CORES=8, BF_PER_CORE=16, LEN_FIRST=128 and LEN_LAST=2.
REQ-030 Sub-module ntt_delay_line (parameterised depth and width, stall-aware shift register) SHALL generate wr_valid, wr_idx and wr_len.

Verification
REQ-031 Reset then start pulse, BF_LATENCY=4 -> len sequence 128,64,32,16,8,4,2; each stage has 16 rd_valid beats then 4 idle cycles; done high in the cycle following edge 140.
REQ-032 Compare rd and wr streams -> wr_valid/wr_idx/wr_len equal rd_valid/rd_idx/len shifted by exactly 4 cycles; 112 beats each.
REQ-033 Assert stall for 3 cycles at rd_idx=7 of len=32 -> outputs frozen; done delayed by exactly 3 cycles (after edge 143).
REQ-034 Pulse start repeatedly while busy -> no restart; exactly one done pulse.
REQ-035 Drop rst_n during len=16 DRAIN -> all outputs 0 asynchronously; a new start produces a full 140-cycle run.
REQ-036 With NTT_CTRL_INTT_EN defined and inverse=1 -> len sequence 2..128; zeta_base 64..1; done timing identical to the forward run.
